// File: rtl/decode_regfile_64.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile_64
// Description : Y86-64 decode-side register file (15 x 64) with E/M write
//               ports, write-to-read bypass and registered operand outputs.
//               Optional macro REGFILE_DEBUG_EN exposes flattened contents.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile_64 #(
    parameter int         NREGS  = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [3:0]  wb_dstE,
    input  logic [63:0] wb_valE,
    input  logic [3:0]  wb_dstM,
    input  logic [63:0] wb_valM,
    output logic        out_valid,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB
`ifdef REGFILE_DEBUG_EN
    ,
    output logic [64*NREGS-1:0] dbg_regs
`endif
);

    localparam logic [3:0] c_RNONE = 4'hF;

    logic [63:0] r_regs [NREGS];
    logic        r_out_valid;
    logic [3:0]  r_srcA;
    logic [3:0]  r_srcB;
    logic [63:0] r_valA;
    logic [63:0] r_valB;

    logic [3:0]  w_srcA;
    logic [3:0]  w_srcB;
    logic [63:0] w_rdA;
    logic [63:0] w_rdB;
    logic [63:0] w_refA;
    logic [63:0] w_refB;
    logic        w_hitA;
    logic        w_hitB;

    // Bypassed read: M port outranks E port, which outranks stored state.
    function automatic logic [63:0] f_read(input logic [3:0] s);
        logic [63:0] v;
        if (s == c_RNONE)
            v = '0;
        else if (s == wb_dstM)
            v = wb_valM;
        else if (s == wb_dstE)
            v = wb_valE;
        else
            v = r_regs[s];
        return v;
    endfunction

    always_comb begin
        w_srcA = c_RNONE;
        w_srcB = c_RNONE;
        case (icode)
            4'h2:    w_srcA = rA;
            4'h4,
            4'h6:    begin w_srcA = rA;     w_srcB = rB;     end
            4'h5:    w_srcB = rB;
            4'h8:    w_srcB = RSP_ID;
            4'h9,
            4'hB:    begin w_srcA = RSP_ID; w_srcB = RSP_ID; end
            4'hA:    begin w_srcA = rA;     w_srcB = RSP_ID; end
            default: ;
        endcase
    end

    always_comb begin
        w_rdA  = f_read(w_srcA);
        w_rdB  = f_read(w_srcB);
        w_refA = f_read(r_srcA);
        w_refB = f_read(r_srcB);
        w_hitA = (r_srcA != c_RNONE) && ((r_srcA == wb_dstM) || (r_srcA == wb_dstE));
        w_hitB = (r_srcB != c_RNONE) && ((r_srcB == wb_dstM) || (r_srcB == wb_dstE));
    end

    // Writes land every edge; M is assigned last so it wins a shared target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            if (wb_dstE != c_RNONE)
                r_regs[wb_dstE] <= wb_valE;
            if (wb_dstM != c_RNONE)
                r_regs[wb_dstM] <= wb_valM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_srcA      <= c_RNONE;
            r_srcB      <= c_RNONE;
            r_valA      <= '0;
            r_valB      <= '0;
        end else if (stall) begin
            // Held operands track writes to their register so they never go stale.
            if (w_hitA)
                r_valA <= w_refA;
            if (w_hitB)
                r_valB <= w_refB;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_srcA      <= w_srcA;
            r_srcB      <= w_srcB;
            r_valA      <= w_rdA;
            r_valB      <= w_rdB;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign srcA      = r_srcA;
    assign srcB      = r_srcB;
    assign valA      = r_valA;
    assign valB      = r_valB;

`ifdef REGFILE_DEBUG_EN
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_dbg
            assign dbg_regs[64*gi +: 64] = r_regs[gi];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile_64.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_regfile_64
// Description : Self-checking bench for decode_regfile_64 against an
//               array-based reference model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_regfile_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall;
    logic [3:0]  icode, rA, rB, wb_dstE, wb_dstM;
    logic [63:0] wb_valE, wb_valM;
    logic        out_valid;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [63:0] m_regs [15];
    logic        e_valid;
    logic [3:0]  e_srcA, e_srcB;
    logic [63:0] e_valA, e_valB;

    decode_regfile_64 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .icode(icode), .rA(rA), .rB(rB),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .out_valid(out_valid), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 4'h2 || ic == 4'h4 || ic == 4'h6 || ic == 4'hA) return ra;
        if (ic == 4'h9 || ic == 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic == 4'h4 || ic == 4'h5 || ic == 4'h6) return rb;
        if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] s);
        if (s == 4'hF) return 64'd0;
        if (s == wb_dstM) return wb_valM;
        if (s == wb_dstE) return wb_valE;
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        e_valid = 1'b0; e_srcA = 4'hF; e_srcB = 4'hF; e_valA = '0; e_valB = '0;
    endtask

    // Called at each rising edge with the inputs that were applied for it.
    task automatic model_edge();
        if (stall) begin
            if (e_srcA != 4'hF && (e_srcA == wb_dstM || e_srcA == wb_dstE)) e_valA = m_read(e_srcA);
            if (e_srcB != 4'hF && (e_srcB == wb_dstM || e_srcB == wb_dstE)) e_valB = m_read(e_srcB);
        end else if (in_valid) begin
            e_valid = 1'b1;
            e_srcA  = m_srcA(icode, rA);
            e_srcB  = m_srcB(icode, rB);
            e_valA  = m_read(e_srcA);
            e_valB  = m_read(e_srcB);
        end else begin
            e_valid = 1'b0;
        end
        if (wb_dstE != 4'hF) m_regs[wb_dstE] = wb_valE;
        if (wb_dstM != 4'hF) m_regs[wb_dstM] = wb_valM;
    endtask

    task automatic step(input logic iv, input logic st, input logic [3:0] ic,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
        in_valid = iv; stall = st; icode = ic; rA = ra; rB = rb;
        wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, e_valid});
            check("srcA", {60'd0, srcA}, {60'd0, e_srcA});
            check("srcB", {60'd0, srcB}, {60'd0, e_srcB});
            check("valA", valA, e_valA);
            check("valB", valB, e_valB);
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 0; stall = 0; icode = 0; rA = 0; rB = 0;
        wb_dstE = 4'hF; wb_dstM = 4'hF; wb_valE = 0; wb_valM = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 0);

        // Write then read
        step(0, 0, 0, 0, 0, 4'd3, 64'h1111, 4'd5, 64'h2222);
        step(1, 0, 4'h6, 4'd3, 4'd5, 4'hF, 0, 4'hF, 0);
        check("wr_rd_valA", valA, 64'h1111);
        check("wr_rd_valB", valB, 64'h2222);
        check("wr_rd_srcA", {60'd0, srcA}, 64'd3);
        check("wr_rd_srcB", {60'd0, srcB}, 64'd5);
        check("wr_rd_valid", {63'd0, out_valid}, 64'd1);

        // Same-cycle bypass
        step(1, 0, 4'h2, 4'd2, 4'hF, 4'd2, 64'hABCD, 4'hF, 0);
        check("bypass_valA", valA, 64'hABCD);
        check("bypass_srcB", {60'd0, srcB}, 64'hF);

        // E/M conflict, popq same cycle
        step(1, 0, 4'hB, 4'hF, 4'hF, 4'd4, 64'h100, 4'd4, 64'h200);
        check("conflict_valA", valA, 64'h200);
        check("conflict_valB", valB, 64'h200);
        step(1, 0, 4'h2, 4'd4, 4'hF, 4'hF, 0, 4'hF, 0);
        check("conflict_reg4", valA, 64'h200);

        // Stall refresh
        step(1, 0, 4'hA, 4'd1, 4'hF, 4'hF, 0, 4'hF, 0);
        check("push_valA", valA, 64'd0);
        check("push_valB", valB, 64'h200);
        step(0, 1, 4'h0, 4'd0, 4'd0, 4'd1, 64'h55, 4'hF, 0);
        check("stall_valA", valA, 64'h55);
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_srcA", {60'd0, srcA}, 64'd1);

        // RNONE / idle
        step(1, 0, 4'h0, 4'd3, 4'd5, 4'hF, 0, 4'hF, 0);
        check("halt_srcA", {60'd0, srcA}, 64'hF);
        check("halt_valB", valB, 64'd0);
        step(0, 0, 4'h6, 4'd3, 4'd5, 4'hF, 0, 4'hF, 0);
        check("idle_valid", {63'd0, out_valid}, 64'd0);
        check("idle_srcB", {60'd0, srcB}, 64'hF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] de, dm;
            de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 de, {$urandom, $urandom}, dm, {$urandom, $urandom});
        end

        // Mid-cycle asynchronous reset
        step(1, 0, 4'h6, 4'd7, 4'd8, 4'd7, 64'h77, 4'd8, 64'h88);
        in_valid = 1; stall = 0; icode = 4'h6; rA = 4'd7; rB = 4'd8;
        wb_dstE = 4'd7; wb_valE = 64'h99; wb_dstM = 4'hF;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_srcA", {60'd0, srcA}, 64'hF);
        check("rst_srcB", {60'd0, srcB}, 64'hF);
        check("rst_valA", valA, 64'd0);
        check("rst_valB", valB, 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 4'h6, 4'(i), 4'(i), 4'hF, 0, 4'hF, 0);
            check("post_rst_zero", valA | valB, 64'd0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_regfile_64.md
Name: decode_regfile_64

Overview:
- Decode-side read partner of the SEQ writeback stage: owns the 15-entry x 64-bit Y86-64 register file.
- Accepts the two writeback write ports (E and M) and derives srcA/srcB from icode/rA/rB.
- Returns registered operands valA/valB one cycle after a decode request.
- Write-to-read bypass guarantees a same-cycle write is visible to a simultaneous read.

Parameters:
- NREGS, 15, number of architectural registers (IDs 0..14); ID 4'hF = RNONE.
- RSP_ID, 4, register ID of %rsp used by stack instructions.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  decode request present this cycle
- stall  input  1  hold all outputs; request not accepted
- icode  input  4  instruction code of request
- rA  input  4  rA field
- rB  input  4  rB field
- wb_dstE  input  4  E-port destination (4'hF = no write)
- wb_valE  input  64  E-port data
- wb_dstM  input  4  M-port destination (4'hF = no write)
- wb_valM  input  64  M-port data
- out_valid  output  1  valA/valB/srcA/srcB valid
- srcA  output  4  registered source A ID
- srcB  output  4  registered source B ID
- valA  output  64  registered operand A
- valB  output  64  registered operand B

Behaviour:
- Reset (rst_n low, async): all 15 registers = 0; out_valid=0; valA=valB=0; srcA=srcB=4'hF. Reset mid-request discards the request; no write lands in that cycle.
- Source decode (combinational, internal):
  - srcA = rA for icode 2, 4, 6, A; RSP_ID for icode 9, B; else F.
  - srcB = rB for icode 4, 5, 6; RSP_ID for icode 8, 9, A, B; else F.
  - Unknown icode gives F/F.
- Writes, every posedge regardless of stall/in_valid:
  - E port writes reg[wb_dstE] when wb_dstE != F.
  - M port writes reg[wb_dstM] when wb_dstM != F.
  - If wb_dstE == wb_dstM != F, M wins (popq %rsp semantics).
- Read value for ID s:
  - F returns 0.
  - Otherwise priority wb_dstM match -> wb_valM, then wb_dstE match -> wb_valE, then stored reg[s].
- Accept (in_valid=1, stall=0) at edge N:
  - srcA/srcB/valA/valB capture decoded IDs and bypassed read values.
  - out_valid=1 from N. Latency 1 cycle.
- Idle (in_valid=0, stall=0): out_valid<=0; srcA/srcB/valA/valB hold last values.
- Stall=1: out_valid, srcA, srcB held; in_valid ignored.
  - A write to held srcA (or srcB) refreshes valA (or valB) using the same M-over-E priority, so held operands never go stale.
  - Held ID F stays 0.
- IDs 0..14 only; no storage for F; writes to F are no-ops.

Optional Feature:
- REGFILE_DEBUG_EN defined:
  - Adds output dbg_regs[64*15-1:0], the flattened current contents.
  - Register i occupies bits [64*i+63:64*i].
  - Registered state only; no bypass.
  - Resets to 0.
- REGFILE_DEBUG_EN undefined: port absent; no other behaviour change.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> outputs clear immediately (out_valid=0, srcA=srcB=F, valA=valB=0); all regs read 0 after release.
- Write then read: E writes reg3=0x1111, M writes reg5=0x2222; next cycle opq (icode 6) rA=3 rB=5 -> after 1 edge valA=0x1111, valB=0x2222, srcA=3, srcB=5, out_valid=1.
- Same-cycle bypass: wb_dstE=2, valE=0xABCD with request rrmovq rA=2 -> valA=0xABCD on the accepting edge.
- Port conflict: wb_dstE=4, valE=0x100 and wb_dstM=4, valM=0x200 -> reg4=0x200; popq request same cycle -> valA=valB=0x200.
- Stall refresh: accept pushq rA=1 (valA=0), then stall=1 while E writes reg1=0x55 -> valA becomes 0x55, out_valid stays 1, srcA stays 1.
- RNONE/idle: halt (icode 0) -> srcA=srcB=F, valA=valB=0. Then in_valid=0 -> out_valid=0, values held.
